// File: rtl/mult_seq_ctrl.sv
// Operand-entry and sequencing controller for the multiplier board: latches two
// switch operands on enter pulses, runs a WIDTH-cycle shift-add multiply, holds the product.
module mult_seq_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   sw,
  input  logic               btn_enter,
  input  logic               btn_clear,
  output logic [WIDTH-1:0]   operand_a,
  output logic [WIDTH-1:0]   operand_b,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         phase,
  output logic               busy,
  output logic               done
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    CALC    = 2'b10,
    DONE    = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [PW-1:0]    product_q, product_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    partial;
  logic [PW-1:0]    sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ENTER_A;
      opa_q     <= '0;
      opb_q     <= '0;
      product_q <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      product_q <= product_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end

  // cnt never exceeds WIDTH-1, so the multiplier bit select stays in range.
  always_comb begin
    partial = '0;
    if (opb_q[cnt_q]) begin
      partial = PW'(opa_q) << cnt_q;
    end
    sum = acc_q + partial;
  end

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    product_d = product_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;

    if (btn_clear) begin
      state_d   = ENTER_A;
      opa_d     = '0;
      opb_d     = '0;
      product_d = '0;
      acc_d     = '0;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        ENTER_A: begin
          if (btn_enter) begin
            opa_d   = sw;
            state_d = ENTER_B;
          end
        end
        ENTER_B: begin
          if (btn_enter) begin
            opb_d   = sw;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
        CALC: begin
          acc_d = sum;
          if (cnt_q == CNT_LAST) begin
            product_d = sum;
            cnt_d     = '0;
            state_d   = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (btn_enter) begin
            state_d = ENTER_A;
          end
        end
        default: state_d = ENTER_A;
      endcase
    end
  end

  assign operand_a = opa_q;
  assign operand_b = opb_q;
  assign product   = product_q;
  assign phase     = state_q;
  assign busy      = (state_q == CALC);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed scenarios plus random button and
// switch activity compared every cycle against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mult_seq_ctrl;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   sw;
  logic           btn_enter;
  logic           btn_clear;
  logic [W-1:0]   operand_a;
  logic [W-1:0]   operand_b;
  logic [2*W-1:0] product;
  logic [1:0]     phase;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;

  // Reference model: phase as an integer, remaining calc cycles, plain multiply.
  int m_ph  = 0;
  int m_a   = 0;
  int m_b   = 0;
  int m_p   = 0;
  int m_rem = 0;

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .btn_enter (btn_enter),
    .btn_clear (btn_clear),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .product   (product),
    .phase     (phase),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_a = 0; m_b = 0; m_p = 0; m_rem = 0;
  endtask

  task automatic model_update(input logic en, input logic cl, input int s);
    if (cl) begin
      model_reset();
    end else begin
      case (m_ph)
        0: if (en) begin m_a = s; m_ph = 1; end
        1: if (en) begin m_b = s; m_ph = 2; m_rem = W; end
        2: begin
          m_rem--;
          if (m_rem == 0) begin
            m_p  = m_a * m_b;
            m_ph = 3;
          end
        end
        default: if (en) m_ph = 0;
      endcase
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_phase"}, 16'(phase), 16'(m_ph));
    chk({tag, "_busy"}, 16'(busy), 16'(m_ph == 2));
    chk({tag, "_done"}, 16'(done), 16'(m_ph == 3));
    chk({tag, "_opa"}, 16'(operand_a), 16'(m_a));
    chk({tag, "_opb"}, 16'(operand_b), 16'(m_b));
    chk({tag, "_prod"}, 16'(product), 16'(m_p));
  endtask

  task automatic step(input string tag, input logic en, input logic cl, input int s);
    btn_enter = en;
    btn_clear = cl;
    sw        = W'(s);
    @(posedge clk);
    #1;
    model_update(en, cl, s);
    compare_all(tag);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
  endtask

  initial begin
    int a, b;
    reset     = 1'b0;
    sw        = '0;
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    #12;
    model_reset();
    compare_all("rst");
    @(negedge clk);
    reset = 1'b1;
    step("idle", 1'b0, 1'b0, 9);

    // 3 x 5: busy for exactly four cycles, then 0x0F.
    step("t1_a", 1'b1, 1'b0, 3);
    step("t1_b", 1'b1, 1'b0, 5);
    chk("t1_busy_start", 16'(busy), 16'd1);
    for (int i = 0; i < 4; i++) step("t1_calc", 1'b0, 1'b0, 0);
    chk("t1_done", 16'(done), 16'd1);
    chk("t1_prod_const", 16'(product), 16'h0F);
    step("t1_back", 1'b1, 1'b0, 0);
    chk("t1_prod_kept", 16'(product), 16'h0F);

    // F x F with enter pulses hammering during CALC.
    step("t2_a", 1'b1, 1'b0, 15);
    step("t2_b", 1'b1, 1'b0, 15);
    chk("t3_ph0", 16'(phase), 16'b10);
    for (int i = 0; i < 3; i++) begin
      step("t3_calc", 1'b1, 1'b0, 4);
      chk("t3_ph", 16'(phase), 16'b10);
    end
    step("t3_last", 1'b1, 1'b0, 4);
    chk("t3_ph_done", 16'(phase), 16'b11);
    chk("t2_prod_const", 16'(product), 16'hE1);
    step("t2_back", 1'b1, 1'b0, 0);

    // 0 x 9: no early exit, still four CALC cycles.
    step("t2z_a", 1'b1, 1'b0, 0);
    step("t2z_b", 1'b1, 1'b0, 9);
    for (int i = 0; i < 3; i++) step("t2z_calc", 1'b0, 1'b0, 0);
    chk("t2z_still_busy", 16'(busy), 16'd1);
    step("t2z_last", 1'b0, 1'b0, 0);
    chk("t2z_prod_const", 16'(product), 16'h00);
    step("t2z_back", 1'b1, 1'b0, 0);

    // Clear on the second CALC cycle.
    step("t4_a", 1'b1, 1'b0, 6);
    step("t4_b", 1'b1, 1'b0, 7);
    step("t4_c1", 1'b0, 1'b0, 0);
    step("t4_clr", 1'b0, 1'b1, 0);
    chk("t4_phase", 16'(phase), 16'b00);
    chk("t4_opa", 16'(operand_a), 16'd0);
    chk("t4_prod", 16'(product), 16'd0);
    chk("t4_busy", 16'(busy), 16'd0);

    // Clear and enter together in ENTER_A: clear wins.
    step("t5", 1'b1, 1'b1, 7);
    chk("t5_opa", 16'(operand_a), 16'd0);
    chk("t5_phase", 16'(phase), 16'b00);

    // Reset mid-CALC, then 3 x 2.
    step("t6_a", 1'b1, 1'b0, 12);
    step("t6_b", 1'b1, 1'b0, 11);
    step("t6_c1", 1'b0, 1'b0, 0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("t6_async");
    @(negedge clk);
    reset = 1'b1;
    step("t6_a2", 1'b1, 1'b0, 3);
    step("t6_b2", 1'b1, 1'b0, 2);
    for (int i = 0; i < 4; i++) step("t6_calc", 1'b0, 1'b0, 0);
    chk("t6_prod_const", 16'(product), 16'h06);
    step("t6_back", 1'b1, 1'b0, 0);

    // Random full multiplications with enter noise during CALC.
    for (int n = 0; n < 20; n++) begin
      a = int'($urandom_range(15, 0));
      b = int'($urandom_range(15, 0));
      step("r_a", 1'b1, 1'b0, a);
      step("r_b", 1'b1, 1'b0, b);
      for (int i = 0; i < 4; i++)
        step("r_calc", 1'($urandom_range(1, 0)), 1'b0, int'($urandom_range(15, 0)));
      chk("r_prod_direct", 16'(product), 16'(a * b));
      step("r_back", 1'b1, 1'b0, int'($urandom_range(15, 0)));
    end

    // Free-running random buttons and switches.
    for (int n = 0; n < 300; n++) begin
      step("rnd", 1'($urandom_range(1, 0)), ($urandom_range(15, 0) == 0),
           int'($urandom_range(15, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
